// File: rtl/sd_dma_ctl.sv
// Sector DMA sequencer between the spi2 byte engine and one DRAM arbiter requester port.
// Latency: cfg_start at cycle N gives busy and the first spi_start/dma_req at N+1; done pulses one cycle after the last word.
// Backpressure: each byte waits for spi_rdy and each DRAM access holds req/addr until dma_ack; no timeouts.
//
// Ports:
//   fclk, rst_n                      clock, async active-low reset
//   cfg_start/dir/addr/len           transfer request (dir 0: SD->RAM, 1: RAM->SD; len 0 = 2**LEN_W words)
//   busy, done                       status; done is a one-cycle pulse with busy already low
//   spi_start, spi_dout, spi_din,
//   spi_rdy                          spi2 byte handshake, low byte of each word first
//   dma_req, dma_rnw, dma_addr,
//   dma_wrdata, dma_bsel, dma_ack,
//   dma_rddata                       arbiter requester port (16-bit words)
//   crc16                            CRC16-CCITT of moved bytes when SD_DMA_CRC16_EN is defined, else 0
module sd_dma_ctl #(
  parameter int ADDR_W = 21,
  parameter int LEN_W  = 8
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_dir,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              spi_start,
  output logic [7:0]        spi_dout,
  input  logic [7:0]        spi_din,
  input  logic              spi_rdy,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [15:0]       dma_wrdata,
  output logic [1:0]        dma_bsel,
  input  logic              dma_ack,
  input  logic [15:0]       dma_rddata,
  output logic [15:0]       crc16
);

  typedef enum logic [2:0] {
    IDLE, RDMEM, SPI_LO, WAIT_LO, SPI_HI, WAIT_HI, WRMEM, FIN
  } state_t;

  state_t           state;
  logic             dir;
  logic [LEN_W:0]   rem;       // one bit wider so len==0 can hold 2**LEN_W
  logic [7:0]       byte_buf;  // dir=1: high byte of the read word; dir=0: received low byte
  logic             last_word;

  assign dma_bsel  = 2'b11;
  assign last_word = (rem == (LEN_W+1)'(1));

  // Outputs are registered and set on the edge that enters a state, so
  // spi_start is high exactly during SPI_LO/SPI_HI and dma_req during RDMEM/WRMEM.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= 1'b0;
      rem        <= '0;
      byte_buf   <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_start  <= 1'b0;
      spi_dout   <= 8'hFF;
      dma_req    <= 1'b0;
      dma_rnw    <= 1'b1;
      dma_addr   <= '0;
      dma_wrdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            dir      <= cfg_dir;
            dma_addr <= cfg_addr;
            rem      <= (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
            busy     <= 1'b1;
            if (cfg_dir) begin
              state   <= RDMEM;
              dma_req <= 1'b1;
              dma_rnw <= 1'b1;
            end else begin
              state     <= SPI_LO;
              spi_start <= 1'b1;
              spi_dout  <= 8'hFF;
            end
          end
        end
        RDMEM: begin
          if (dma_ack) begin
            dma_req   <= 1'b0;
            byte_buf  <= dma_rddata[15:8];
            state     <= SPI_LO;
            spi_start <= 1'b1;
            spi_dout  <= dma_rddata[7:0];
          end
        end
        SPI_LO: begin
          spi_start <= 1'b0;
          state     <= WAIT_LO;
        end
        WAIT_LO: begin
          if (spi_rdy) begin
            if (!dir) byte_buf <= spi_din;
            state     <= SPI_HI;
            spi_start <= 1'b1;
            spi_dout  <= dir ? byte_buf : 8'hFF;
          end
        end
        SPI_HI: begin
          spi_start <= 1'b0;
          state     <= WAIT_HI;
        end
        WAIT_HI: begin
          if (spi_rdy) begin
            if (!dir) begin
              state      <= WRMEM;
              dma_req    <= 1'b1;
              dma_rnw    <= 1'b0;
              dma_wrdata <= {spi_din, byte_buf};
            end else begin
              // next-word step (RAM->SD)
              dma_addr <= dma_addr + ADDR_W'(1);
              rem      <= rem - (LEN_W+1)'(1);
              if (last_word) begin
                state    <= FIN;
                done     <= 1'b1;
                busy     <= 1'b0;
                spi_dout <= 8'hFF;
              end else begin
                state   <= RDMEM;
                dma_req <= 1'b1;
                dma_rnw <= 1'b1;
              end
            end
          end
        end
        WRMEM: begin
          if (dma_ack) begin
            dma_req  <= 1'b0;
            // next-word step (SD->RAM)
            dma_addr <= dma_addr + ADDR_W'(1);
            rem      <= rem - (LEN_W+1)'(1);
            if (last_word) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= SPI_LO;
              spi_start <= 1'b1;
              spi_dout  <= 8'hFF;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SD_DMA_CRC16_EN
  // CRC16-CCITT, poly 0x1021, MSB first, one byte per call.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // A byte counts as moved when spi_rdy completes it; during WAIT_* spi_dout
  // still holds the byte that was shifted out.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      crc16 <= 16'h0000;
    end else if (state == IDLE && cfg_start) begin
      crc16 <= 16'h0000;
    end else if (spi_rdy && (state == WAIT_LO || state == WAIT_HI)) begin
      crc16 <= crc_byte(crc16, dir ? spi_dout : spi_din);
    end
  end
`else
  assign crc16 = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_dma_ctl.sv
module tb_sd_dma_ctl;

  logic        fclk;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_dir;
  logic [20:0] cfg_addr;
  logic [7:0]  cfg_len;
  logic        busy;
  logic        done;
  logic        spi_start;
  logic [7:0]  spi_dout;
  logic [7:0]  spi_din;
  logic        spi_rdy;
  logic        dma_req;
  logic        dma_rnw;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic [1:0]  dma_bsel;
  logic        dma_ack;
  logic [15:0] dma_rddata;
  logic [15:0] crc16;

  sd_dma_ctl dut (
    .fclk(fclk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done),
    .spi_start(spi_start), .spi_dout(spi_dout), .spi_din(spi_din), .spi_rdy(spi_rdy),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_bsel(dma_bsel), .dma_ack(dma_ack), .dma_rddata(dma_rddata), .crc16(crc16)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus queues (filled by the main flow) and logs (filled by the models)
  logic [7:0]  rx_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  sent_q[$];
  logic [20:0] rd_addr_q[$];
  logic [20:0] wr_addr_q[$];
  logic [15:0] wr_dat_q[$];
  int n_start = 0, n_rdy = 0, n_ovl = 0, n_unstable = 0, n_done = 0, n_done_busy = 0;
  int ack_dly = 1;
  int spur_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // spi2 model: 3 cycles from start to rdy; can also fire a spurious rdy on request
  initial begin : spi_model
    int spur_seen;
    spur_seen = 0;
    spi_rdy = 1'b0;
    spi_din = 8'h00;
    forever begin
      @(negedge fclk);
      spi_rdy = 1'b0;
      if (spi_start) begin
        sent_q.push_back(spi_dout);
        n_start++;
        repeat (3) begin
          @(negedge fclk);
          if (spi_start) n_ovl++;
        end
        spi_din = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        spi_rdy = 1'b1;
        n_rdy++;
      end else if (spur_seen != spur_cnt) begin
        spur_seen++;
        spi_din = 8'hA5;
        spi_rdy = 1'b1;
      end
    end
  end

  // DRAM arbiter model: acks after ack_dly cycles, checks req/addr/rnw hold steady
  initial begin : dram_model
    logic [20:0] a;
    logic        rnw;
    dma_ack = 1'b0;
    dma_rddata = 16'h0000;
    forever begin
      @(negedge fclk);
      dma_ack = 1'b0;
      if (dma_req && rst_n) begin
        a = dma_addr;
        rnw = dma_rnw;
        repeat (ack_dly) begin
          @(negedge fclk);
          if (!dma_req || dma_addr !== a || dma_rnw !== rnw) n_unstable++;
        end
        if (rnw) begin
          rd_addr_q.push_back(a);
          dma_rddata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
        end else begin
          wr_addr_q.push_back(a);
          wr_dat_q.push_back(dma_wrdata);
        end
        dma_ack = 1'b1;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge fclk);
      if (done) begin
        n_done++;
        if (busy) n_done_busy++;
      end
    end
  end

  task automatic clear_logs();
    sent_q.delete();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_dat_q.delete();
    rx_q.delete();
    rd_q.delete();
  endtask

  // pulse cfg_start and check the first-cycle response
  task automatic start_xfer(input string tag, input logic dir, input logic [20:0] addr, input logic [7:0] len);
    @(negedge fclk);
    cfg_dir = dir; cfg_addr = addr; cfg_len = len; cfg_start = 1'b1;
    @(negedge fclk);
    cfg_start = 1'b0;
    chk({tag, " busy@N+1"}, {31'b0, busy}, 1);
    if (dir) chk({tag, " dma_req@N+1"}, {31'b0, dma_req}, 1);
    else     chk({tag, " spi_start@N+1"}, {31'b0, spi_start}, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      @(negedge fclk);
    end
    chk({tag, " done seen"}, {31'b0, done}, 1);
    @(negedge fclk);
    chk({tag, " done one cycle"}, {31'b0, done}, 0);
    chk({tag, " busy after"}, {31'b0, busy}, 0);
  endtask

  initial begin : main
    int d0, s0, w, bad_ff;
    logic [15:0] exp_crc;
    logic [7:0]  bytes[4];

    rst_n = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_addr = '0; cfg_len = '0;
    repeat (3) @(negedge fclk);
    // reset values
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst spi_start", {31'b0, spi_start}, 0);
    chk("rst spi_dout", {24'b0, spi_dout}, 32'hFF);
    chk("rst dma_req", {31'b0, dma_req}, 0);
    chk("rst dma_rnw", {31'b0, dma_rnw}, 1);
    chk("rst dma_addr", {11'b0, dma_addr}, 0);
    chk("rst dma_wrdata", {16'b0, dma_wrdata}, 0);
    chk("rst dma_bsel", {30'b0, dma_bsel}, 3);
    chk("rst crc16", {16'b0, crc16}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge fclk);

    // SD->RAM, two words
    clear_logs();
    d0 = n_done; s0 = n_start;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    exp_crc = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      rx_q.push_back(bytes[i]);
      exp_crc = crc_ref(exp_crc, bytes[i]);
    end
`ifndef SD_DMA_CRC16_EN
    exp_crc = 16'h0000;
`endif
    start_xfer("s2r", 1'b0, 21'h001000, 8'd2);
    wait_done("s2r", 400);
    chk("s2r writes", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      chk("s2r wr0 addr", {11'b0, wr_addr_q[0]}, 32'h1000);
      chk("s2r wr0 data", {16'b0, wr_dat_q[0]}, 32'h2211);
      chk("s2r wr1 addr", {11'b0, wr_addr_q[1]}, 32'h1001);
      chk("s2r wr1 data", {16'b0, wr_dat_q[1]}, 32'h4433);
    end
    bad_ff = 0;
    foreach (sent_q[i]) if (sent_q[i] !== 8'hFF) bad_ff++;
    chk("s2r spi_dout not FF", bad_ff, 0);
    chk("s2r spi_starts", n_start - s0, 4);
    chk("s2r done pulses", n_done - d0, 1);
    chk("s2r crc16", {16'b0, crc16}, {16'b0, exp_crc});

    // RAM->SD, address wraps at the top of DRAM
    clear_logs();
    d0 = n_done;
    rd_q.push_back(16'hBEEF);
    rd_q.push_back(16'h1234);
    bytes[0] = 8'hEF; bytes[1] = 8'hBE; bytes[2] = 8'h34; bytes[3] = 8'h12;
    exp_crc = 16'h0000;
    for (int i = 0; i < 4; i++) exp_crc = crc_ref(exp_crc, bytes[i]);
`ifndef SD_DMA_CRC16_EN
    exp_crc = 16'h0000;
`endif
    start_xfer("r2s", 1'b1, 21'h1FFFFF, 8'd2);
    wait_done("r2s", 400);
    chk("r2s bytes sent", sent_q.size(), 4);
    if (sent_q.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("r2s byte%0d", i), {24'b0, sent_q[i]}, {24'b0, bytes[i]});
    chk("r2s reads", rd_addr_q.size(), 2);
    if (rd_addr_q.size() == 2) begin
      chk("r2s rd0 addr", {11'b0, rd_addr_q[0]}, 32'h1FFFFF);
      chk("r2s rd1 addr wrap", {11'b0, rd_addr_q[1]}, 32'h000000);
    end
    chk("r2s writes", wr_addr_q.size(), 0);
    chk("r2s done pulses", n_done - d0, 1);
    chk("r2s crc16", {16'b0, crc16}, {16'b0, exp_crc});

    // len=0 -> 256 words of 0xFFFF
    clear_logs();
    d0 = n_done; s0 = n_start;
    for (int i = 0; i < 512; i++) rx_q.push_back(8'hFF);
    start_xfer("len0", 1'b0, 21'h000100, 8'd0);
    wait_done("len0", 8000);
    chk("len0 writes", wr_addr_q.size(), 256);
    chk("len0 spi_starts", n_start - s0, 512);
    chk("len0 end addr", {11'b0, dma_addr}, 32'h200);
    w = wr_addr_q.size();
    if (w > 0) begin
      chk("len0 last wr addr", {11'b0, wr_addr_q[w-1]}, 32'h1FF);
      chk("len0 last wr data", {16'b0, wr_dat_q[w-1]}, 32'hFFFF);
    end
    chk("len0 done pulses", n_done - d0, 1);
`ifdef SD_DMA_CRC16_EN
    chk("len0 crc16 0x7FA1", {16'b0, crc16}, 32'h7FA1);
`else
    chk("len0 crc16 off", {16'b0, crc16}, 0);
`endif

    // slow ack, spurious spi_rdy in RDMEM, cfg_start while busy
    clear_logs();
    d0 = n_done; s0 = n_start;
    ack_dly = 20;
    rd_q.push_back(16'hCAFE);
    exp_crc = crc_ref(crc_ref(16'h0000, 8'hFE), 8'hCA);
`ifndef SD_DMA_CRC16_EN
    exp_crc = 16'h0000;
`endif
    start_xfer("slow", 1'b1, 21'h002000, 8'd1);
    cfg_dir = 1'b0; cfg_addr = 21'h003000; cfg_len = 8'd5; cfg_start = 1'b1;
    spur_cnt++;
    @(negedge fclk);
    cfg_start = 1'b0;
    chk("slow req held", {31'b0, dma_req}, 1);
    chk("slow addr kept", {11'b0, dma_addr}, 32'h2000);
    chk("slow rnw kept", {31'b0, dma_rnw}, 1);
    wait_done("slow", 400);
    chk("slow unstable req", n_unstable, 0);
    chk("slow reads", rd_addr_q.size(), 1);
    chk("slow spi_starts", n_start - s0, 2);
    if (sent_q.size() == 2) begin
      chk("slow byte0", {24'b0, sent_q[0]}, 32'hFE);
      chk("slow byte1", {24'b0, sent_q[1]}, 32'hCA);
    end
    chk("slow end addr", {11'b0, dma_addr}, 32'h2001);
    chk("slow done pulses", n_done - d0, 1);
    chk("slow crc16", {16'b0, crc16}, {16'b0, exp_crc});
    ack_dly = 1;

    // reset in the middle of a transfer
    clear_logs();
    d0 = n_done; s0 = n_rdy;
    for (int i = 0; i < 8; i++) rx_q.push_back(8'h40 + 8'(i));
    start_xfer("mid", 1'b0, 21'h004000, 8'd4);
    for (int c = 0; c < 200; c++) begin
      if (n_rdy - s0 >= 3) break;
      @(negedge fclk);
    end
    chk("mid 3 bytes reached", n_rdy - s0, 3);
    repeat (2) @(negedge fclk);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", {31'b0, busy}, 0);
    chk("mid rst spi_start", {31'b0, spi_start}, 0);
    chk("mid rst spi_dout", {24'b0, spi_dout}, 32'hFF);
    chk("mid rst dma_req", {31'b0, dma_req}, 0);
    chk("mid rst dma_rnw", {31'b0, dma_rnw}, 1);
    chk("mid rst dma_addr", {11'b0, dma_addr}, 0);
    chk("mid rst dma_wrdata", {16'b0, dma_wrdata}, 0);
    chk("mid rst crc16", {16'b0, crc16}, 0);
    chk("mid writes before rst", wr_addr_q.size(), 1);
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;
    repeat (6) @(negedge fclk);
    chk("mid no done", n_done - d0, 0);
    chk("mid idle after rst", {31'b0, busy}, 0);

    clear_logs();
    d0 = n_done;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    start_xfer("post", 1'b0, 21'h005000, 8'd1);
    wait_done("post", 400);
    chk("post writes", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      chk("post wr addr", {11'b0, wr_addr_q[0]}, 32'h5000);
      chk("post wr data", {16'b0, wr_dat_q[0]}, 32'h0201);
    end
    chk("post done pulses", n_done - d0, 1);

    chk("spi_start overlap", n_ovl, 0);
    chk("done with busy", n_done_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
